// File: rtl/gpu_cmd_feeder_if.sv
// Producer-side word stream into gpu_cmd_feeder.
//   s_valid : producer presents a word
//   s_gp1   : 1 = word targets GP1, 0 = GP0
//   s_data  : 32-bit command/parameter word
//   s_ready : feeder can accept; a word is pushed when s_valid & s_ready
// master = producer (CPU bus bridge / DMA), slave = feeder.
interface gpu_cmd_feeder_if;
    logic        s_valid;
    logic        s_gp1;
    logic [31:0] s_data;
    logic        s_ready;

    modport master (output s_valid, output s_gp1, output s_data, input s_ready);
    modport slave  (input s_valid, input s_gp1, input s_data, output s_ready);
endinterface

// File: rtl/gpu_cmd_feeder.sv
// gpu_cmd_feeder: buffers GP0/GP1 command words and replays each one as a
// single-cycle write pulse on the gpu CPU-side write port. GP0 words wait
// for o_canWrite; GP1 words go out regardless. Order is strictly preserved.
// Ports:
//   clk, i_nrst     clock, asynchronous active-low reset
//   s_if (slave)    producer stream: s_valid/s_gp1/s_data in, s_ready out
//   i_flush         discard all buffered, not-yet-issued words
//   o_canWrite      gpu GP0 FIFO can accept (input despite its name)
//   gpuSel, write   one-cycle write strobe pair
//   gpuAdrA2        0 = GP0, 1 = GP1 (only during the strobe)
//   cpuDataIn       word being written; holds its last value afterwards
//   o_level         words currently buffered
//   o_busy          buffer non-empty or a write/gap in progress
//   o_issuedCnt     words issued since reset (wraps)
//
// state | meaning
// IDLE  | waiting for a head word that may issue
// ISSUE | write pulse on the gpu port (exactly one cycle)
// GAP   | forced idle cycles after a pulse
module gpu_cmd_feeder #(
    parameter int DEPTH_LOG2 = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  i_nrst,
    gpu_cmd_feeder_if.slave       s_if,
    input  logic                  i_flush,
    input  logic                  o_canWrite,
    output logic                  gpuSel,
    output logic                  gpuAdrA2,
    output logic                  write,
    output logic [31:0]           cpuDataIn,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_busy,
    output logic [31:0]           o_issuedCnt
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LVL_W = DEPTH_LOG2 + 1;
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_GAP} state_t;

    state_t                r_state, w_state_nxt;
    logic [32:0]           r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
    logic [LVL_W-1:0]      r_level, w_level_nxt;
    logic                  r_empty, r_ready;
    logic [3:0]            r_gap_cnt;
    logic [31:0]           r_data;
    logic                  r_adr;
    logic [31:0]           r_issued;
    logic                  w_push, w_pop, w_issue;
    logic [32:0]           w_head;

    assign w_head  = r_mem[r_rd_ptr];
    // A push coinciding with a flush is dropped along with everything else.
    assign w_push  = s_if.s_valid & r_ready & ~i_flush;
    assign w_issue = (r_state == ST_ISSUE);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_empty && !i_flush && (w_head[32] || o_canWrite)) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:   if (r_gap_cnt == 4'd0) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_level_nxt = r_level;
        if (i_flush)
            w_level_nxt = '0;
        else if (w_push && !w_pop)
            w_level_nxt = r_level + LVL_W'(1);
        else if (!w_push && w_pop)
            w_level_nxt = r_level - LVL_W'(1);
    end

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Full/empty are registered from the next level, so s_ready never looks
    // ahead at a same-cycle pop.
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_empty  <= 1'b1;
            r_ready  <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            r_empty <= (w_level_nxt == '0);
            r_ready <= (w_level_nxt != LVL_W'(DEPTH));
            if (i_flush) begin
                r_rd_ptr <= r_wr_ptr;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {s_if.s_gp1, s_if.s_data};
    end

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_data    <= '0;
            r_adr     <= 1'b0;
            r_issued  <= '0;
            r_gap_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_data <= w_head[31:0];
                r_adr  <= w_head[32];
            end
            if (w_issue) begin
                r_issued  <= r_issued + 32'd1;
                r_gap_cnt <= GAP_LOAD;
            end else if (r_state == ST_GAP && r_gap_cnt != 4'd0) begin
                r_gap_cnt <= r_gap_cnt - 4'd1;
            end
        end
    end

    assign s_if.s_ready = r_ready;
    assign write        = w_issue;
    assign gpuSel       = w_issue;
    assign gpuAdrA2     = w_issue & r_adr;
    assign cpuDataIn    = r_data;
    assign o_level      = r_level;
    assign o_busy       = ~r_empty | (r_state != ST_IDLE);
    assign o_issuedCnt  = r_issued;
endmodule

// File: tb/tb_gpu_cmd_feeder.sv
// Directed bench for gpu_cmd_feeder (DEPTH_LOG2=4, GAP_CYCLES=1).
// A negedge monitor logs every write pulse (data, address bit, cycle) and
// flags back-to-back pulses or a gpuSel/write disagreement.
module tb_gpu_cmd_feeder;
    logic        clk;
    logic        i_nrst;
    logic        i_flush;
    logic        o_canWrite;
    logic        gpuSel, gpuAdrA2, write;
    logic [31:0] cpuDataIn;
    logic [4:0]  o_level;
    logic        o_busy;
    logic [31:0] o_issuedCnt;

    gpu_cmd_feeder_if u_if ();

    gpu_cmd_feeder #(.DEPTH_LOG2(4), .GAP_CYCLES(1)) dut (
        .clk         (clk),
        .i_nrst      (i_nrst),
        .s_if        (u_if),
        .i_flush     (i_flush),
        .o_canWrite  (o_canWrite),
        .gpuSel      (gpuSel),
        .gpuAdrA2    (gpuAdrA2),
        .write       (write),
        .cpuDataIn   (cpuDataIn),
        .o_level     (o_level),
        .o_busy      (o_busy),
        .o_issuedCnt (o_issuedCnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [31:0] log_data[$];
    logic        log_adr[$];
    int          log_cyc[$];
    logic        prev_write = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (write === 1'b1) begin
            checks++;
            if (prev_write === 1'b1 || gpuSel !== 1'b1) begin
                errors++;
                $display("FAIL strobe: write=%b prev_write=%b gpuSel=%b (need prev 0, gpuSel 1)",
                         write, prev_write, gpuSel);
            end
            log_data.push_back(cpuDataIn);
            log_adr.push_back(gpuAdrA2);
            log_cyc.push_back(cyc);
        end
        prev_write = write;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic gp1, input logic [31:0] data);
        u_if.s_valid = 1'b1;
        u_if.s_gp1   = gp1;
        u_if.s_data  = data;
        @(negedge clk);
        u_if.s_valid = 1'b0;
    endtask

    task automatic clear_log();
        log_data.delete();
        log_adr.delete();
        log_cyc.delete();
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int b = budget;
        while (log_data.size() < n && b > 0) begin
            tick(1);
            b--;
        end
        checks++;
        if (log_data.size() < n) begin
            errors++;
            $display("FAIL %s timeout: got %0d pulses, need %0d", name, log_data.size(), n);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h need 0x%08h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        i_nrst       = 1'b0;
        i_flush      = 1'b0;
        o_canWrite   = 1'b1;
        u_if.s_valid = 1'b1;
        u_if.s_gp1   = 1'b0;
        u_if.s_data  = 32'h1234_5678;
        tick(3);
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_ready", {31'd0, u_if.s_ready}, 32'd0);
        chk("rst_level", {27'd0, o_level}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_cnt", o_issuedCnt, 32'd0);
        chk("rst_data", cpuDataIn, 32'd0);
        u_if.s_valid = 1'b0;
        i_nrst       = 1'b1;
        tick(1);
        chk("rel_ready", {31'd0, u_if.s_ready}, 32'd1);
        chk("rel_level", {27'd0, o_level}, 32'd0);
        tick(3);
        chk("rst_nopulse", log_data.size(), 32'd0);
    endtask

    task automatic test_two_gp0();
        int k;
        clear_log();
        o_canWrite = 1'b1;
        k = cyc;
        push(1'b0, 32'h380000B2);
        push(1'b0, 32'h00F000C0);
        wait_log(2, 20, "two_gp0");
        tick(2);
        if (log_data.size() >= 2) begin
            chk("two_d0", log_data[0], 32'h380000B2);
            chk("two_a0", {31'd0, log_adr[0]}, 32'd0);
            chk("two_d1", log_data[1], 32'h00F000C0);
            chk("two_a1", {31'd0, log_adr[1]}, 32'd0);
            chk("two_latency", log_cyc[0] - k, 32'd2);
            chk("two_spacing", log_cyc[1] - log_cyc[0], 32'd3);
        end
        chk("two_cnt", o_issuedCnt, 32'd2);
        chk("two_busy", {31'd0, o_busy}, 32'd0);
    endtask

    task automatic test_gp0_blocked();
        clear_log();
        o_canWrite = 1'b0;
        push(1'b0, 32'h00008CB2);
        push(1'b1, 32'h08000000);
        tick(6);
        chk("blk_nopulse", log_data.size(), 32'd0);
        chk("blk_level", {27'd0, o_level}, 32'd2);
        chk("blk_busy", {31'd0, o_busy}, 32'd1);
        o_canWrite = 1'b1;
        wait_log(2, 20, "blk_drain");
        tick(2);
        if (log_data.size() >= 2) begin
            chk("blk_d0", log_data[0], 32'h00008CB2);
            chk("blk_a0", {31'd0, log_adr[0]}, 32'd0);
            chk("blk_d1", log_data[1], 32'h08000000);
            chk("blk_a1", {31'd0, log_adr[1]}, 32'd1);
        end
        chk("blk_cnt", o_issuedCnt, 32'd4);
    endtask

    task automatic test_gp1_bypass();
        clear_log();
        o_canWrite = 1'b0;
        push(1'b1, 32'h01000000);
        wait_log(1, 10, "gp1_issue");
        tick(2);
        if (log_data.size() >= 1) begin
            chk("gp1_d", log_data[0], 32'h01000000);
            chk("gp1_a", {31'd0, log_adr[0]}, 32'd1);
        end
        chk("gp1_cnt", o_issuedCnt, 32'd5);
    endtask

    task automatic test_full();
        clear_log();
        o_canWrite = 1'b0;
        for (int i = 0; i < 16; i++) push(1'b0, 32'h0000_1000 + i);
        chk("full_level", {27'd0, o_level}, 32'd16);
        chk("full_ready", {31'd0, u_if.s_ready}, 32'd0);
        u_if.s_valid = 1'b1;
        u_if.s_gp1   = 1'b0;
        u_if.s_data  = 32'hDEAD_BEEF;
        tick(2);
        u_if.s_valid = 1'b0;
        chk("full_17th", {27'd0, o_level}, 32'd16);
        o_canWrite = 1'b1;
        chk("full_ready_pre", {31'd0, u_if.s_ready}, 32'd0);
        tick(1);
        chk("full_ready_pop", {31'd0, u_if.s_ready}, 32'd1);
        chk("full_level_pop", {27'd0, o_level}, 32'd15);
        wait_log(16, 70, "full_drain");
        tick(3);
        chk("full_count", log_data.size(), 32'd16);
        for (int i = 0; i < 16 && i < log_data.size(); i++)
            chk($sformatf("full_d%0d", i), log_data[i], 32'h0000_1000 + i);
        chk("full_cnt", o_issuedCnt, 32'd21);
    endtask

    task automatic test_flush();
        int b = 20;
        clear_log();
        o_canWrite = 1'b0;
        push(1'b0, 32'h000000A0);
        push(1'b0, 32'h000000A1);
        push(1'b0, 32'h000000A2);
        push(1'b0, 32'h000000A3);
        o_canWrite = 1'b1;
        while (write !== 1'b1 && b > 0) begin
            tick(1);
            b--;
        end
        checks++;
        if (write !== 1'b1) begin
            errors++;
            $display("FAIL flush_wait timeout: write=%b need 1", write);
        end
        i_flush      = 1'b1;
        o_canWrite   = 1'b0;
        u_if.s_valid = 1'b1;
        u_if.s_gp1   = 1'b1;
        u_if.s_data  = 32'h0000_0BAD;
        tick(1);
        i_flush      = 1'b0;
        u_if.s_valid = 1'b0;
        chk("flush_level", {27'd0, o_level}, 32'd0);
        tick(1);
        chk("flush_busy", {31'd0, o_busy}, 32'd0);
        o_canWrite = 1'b1;
        tick(10);
        chk("flush_pulses", log_data.size(), 32'd1);
        if (log_data.size() >= 1) chk("flush_d0", log_data[0], 32'h000000A0);
        chk("flush_cnt", o_issuedCnt, 32'd22);
    endtask

    task automatic test_reset_mid();
        int b = 20;
        clear_log();
        o_canWrite = 1'b1;
        push(1'b0, 32'h000000B2);
        push(1'b0, 32'h000000B3);
        while (write !== 1'b1 && b > 0) begin
            tick(1);
            b--;
        end
        checks++;
        if (write !== 1'b1) begin
            errors++;
            $display("FAIL rmid_wait timeout: write=%b need 1", write);
        end
        chk("rmid_data", cpuDataIn, 32'h000000B2);
        #2 i_nrst = 1'b0;
        #1;
        chk("rmid_write", {31'd0, write}, 32'd0);
        chk("rmid_sel", {31'd0, gpuSel}, 32'd0);
        chk("rmid_level", {27'd0, o_level}, 32'd0);
        @(negedge clk);
        i_nrst = 1'b1;
        tick(8);
        chk("rmid_cnt", o_issuedCnt, 32'd0);
        chk("rmid_pulses", log_data.size(), 32'd1);
        chk("rmid_busy", {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        test_reset();
        test_two_gp0();
        test_gp0_blocked();
        test_gp1_bypass();
        test_full();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
